regfile_mp: RTL

Parametrised multi-read-port register file with a hardware clear sequencer. Entry 0 is optionally hardwired to zero, and same-cycle write-to-read bypass is optional. It sits in the rv32i decode/writeback path and replaces the fixed 2-read, 32×32 file. It generalises width, depth and read-port count. After reset or an explicit clear request, it zeroes every entry over DEPTH cycles and reports `busy` so the pipeline can stall.

---
 rtl/regfile_mp.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parameterised multi-read-port register file with a hardware clear sequencer.
// Define RV32I_REGFILE_ZERO_REG_EN to hardwire entry 0 to zero (RISC-V x0 semantics).

typedef enum logic {
    REG_WE_OFF = 1'b0,
    REG_WE     = 1'b1
} reg_we_e;

module regfile_mp #(
    parameter int unsigned  XLEN   = 32,
    parameter int unsigned  DEPTH  = 32,
    parameter int unsigned  NUM_RD = 2,
    parameter int unsigned  BYPASS = 1,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  reg_we_e                  we,
    input  logic [AW-1:0]            rd_addr,
    input  logic [XLEN-1:0]          rd_data,
    input  logic [NUM_RD*AW-1:0]     rs_addr,
    output logic [NUM_RD*XLEN-1:0]   rs_data,
    output logic                     busy
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

`ifdef RV32I_REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [DEPTH];
    logic            wr_en;
    logic            clr_en;

    assign busy   = (state_q == CLEAR);
    assign clr_en = !rst && (state_q == CLEAR);
    // A write in the cycle a clear is accepted still commits; the clear erases it later.
    assign wr_en  = !rst && (state_q == READY) && (we == REG_WE)
                    && !(ZERO_REG && (rd_addr == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage has no reset of its own; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[rd_addr] <= rd_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rs_addr[i*AW +: AW];

        always_comb begin
            if (busy) begin
                data = '0;
            end else if (ZERO_REG && (addr == '0)) begin
                data = '0;
            end else if ((BYPASS != 0) && (we == REG_WE) && (rd_addr == addr)) begin
                data = rd_data;
            end else begin
                data = mem_q[addr];
            end
        end

        assign rs_data[i*XLEN +: XLEN] = data;
    end

endmodule
